// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: widths, PC-1 selection, rotation schedule, FSM states.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  // PC-1: entry j is the DES key bit number (1-based) that becomes CD bit j+1.
  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Left-rotation amount for rounds 1..16 (index 0 = round 1); totals 28.
  localparam logic [1:0] SHIFT_SCHED [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/pc1.sv
// PC-1 permuted choice: selects the 56 key bits into C0/D0, dropping the eight parity bits.
module pc1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] i_key,
  output logic [CD_W-1:0]  o_cd
);

  // Parity bits (DES bits 8,16,...,64) carry no key material; folded here only to keep them visibly consumed.
  logic w_parity_unused;
  assign w_parity_unused = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                             i_key[24], i_key[16], i_key[8],  i_key[0]};

  // DES bit n of a W-bit bus lives at index W-n.
  for (genvar j = 0; j < CD_W; j++) begin : g_sel
    assign o_cd[CD_W-1-j] = i_key[KEY_W-PC1_TBL[j]];
  end

endmodule

// File: rtl/pc2.sv
// PC-2 permuted choice: compresses the 56-bit C/D state into a 48-bit round subkey.
module pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);

  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // CD bits 9,18,22,25,35,38,43,54 are never selected by PC-2.
  logic w_drop_unused;
  assign w_drop_unused = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                           i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_sel
    assign o_subkey[SUBKEY_W-1-j] = i_cd[CD_W-PC2_TBL[j]];
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: accepts a key, then hands out 16 PC-2 subkeys over valid/ready,
// in encrypt (K1..K16) or decrypt (K16..K1) order.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a key; key_ready=1
// ST_ROUND | presenting PC2(cd) for round r_rcnt; advances on subkey_ready
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                decrypt,
  input  logic                key_valid,
  output logic                key_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                done
);

  sched_state_e      r_state, w_state_nxt;
  logic [CD_W-1:0]   r_cd, w_cd_nxt;
  logic [3:0]        r_rcnt, w_rcnt_nxt;
  logic              r_mode, w_mode_nxt;
  logic              r_done, w_done_nxt;
  logic [CD_W-1:0]   w_pc1;

  // Rotates C and D independently by 1 or 2 places; left walks toward DES bit 1 (the MSB).
  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd,
                                             input logic [1:0]      amt,
                                             input logic            left);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[CD_W-1:HALF_W];
    d = cd[HALF_W-1:0];
    if (left) begin
      if (amt == 2'd2) begin
        c = {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2]};
        d = {d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]};
      end else begin
        c = {c[HALF_W-2:0], c[HALF_W-1]};
        d = {d[HALF_W-2:0], d[HALF_W-1]};
      end
    end else begin
      if (amt == 2'd2) begin
        c = {c[1:0], c[HALF_W-1:2]};
        d = {d[1:0], d[HALF_W-1:2]};
      end else begin
        c = {c[0], c[HALF_W-1:1]};
        d = {d[0], d[HALF_W-1:1]};
      end
    end
    return {c, d};
  endfunction

  pc1 u_pc1 (
    .i_key (key_in),
    .o_cd  (w_pc1)
  );

  pc2 u_pc2 (
    .i_cd     (r_cd),
    .o_subkey (subkey)
  );

  assign round_idx = r_rcnt;
  assign done      = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Schedule datapath registers: C/D state, round counter, latched mode, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cd   <= '0;
      r_rcnt <= '0;
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cd   <= w_cd_nxt;
      r_rcnt <= w_rcnt_nxt;
      r_mode <= w_mode_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Next-state, datapath update and handshake outputs.
  // Decrypt starts from C0D0 (== C16D16) and walks backwards, undoing S[16], S[15], ... in turn.
  always_comb begin
    w_state_nxt  = r_state;
    w_cd_nxt     = r_cd;
    w_rcnt_nxt   = r_rcnt;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;
    key_ready    = 1'b0;
    subkey_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          w_mode_nxt  = decrypt;
          w_cd_nxt    = decrypt ? w_pc1 : rot_cd(w_pc1, SHIFT_SCHED[0], 1'b1);
          w_rcnt_nxt  = '0;
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        subkey_valid = 1'b1;
        if (subkey_ready) begin
          if (r_rcnt == LAST_ROUND) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 4'd1;
            if (r_mode) begin
              w_cd_nxt = rot_cd(r_cd, SHIFT_SCHED[LAST_ROUND - r_rcnt], 1'b0);
            end else begin
              w_cd_nxt = rot_cd(r_cd, SHIFT_SCHED[r_rcnt + 4'd1], 1'b1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl against a bit-level DES key schedule model.
module tb_des_key_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] exp_sk [16];
  logic [47:0] got_sk [16];

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;

  int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Textbook key schedule on arrays of DES bits: C/D halves rotated round by round, PC-2 per round.
  task automatic build_exp(input logic [63:0] k, input logic dec);
    bit          c [28];
    bit          d [28];
    bit          t;
    logic [47:0] ks [16];
    logic [47:0] sk;
    int          p;
    for (int i = 0; i < 28; i++) begin
      c[i] = k[64 - PC1_T[i]];
      d[i] = k[64 - PC1_T[i + 28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH[r]; s++) begin
        t = c[0];
        for (int i = 0; i < 27; i++) c[i] = c[i + 1];
        c[27] = t;
        t = d[0];
        for (int i = 0; i < 27; i++) d[i] = d[i + 1];
        d[27] = t;
      end
      sk = '0;
      for (int j = 0; j < 48; j++) begin
        p = PC2_T[j];
        sk[47 - j] = (p <= 28) ? c[p - 1] : d[p - 29];
      end
      ks[r] = sk;
    end
    for (int i = 0; i < 16; i++) exp_sk[i] = dec ? ks[15 - i] : ks[i];
  endtask

  // Runs one key through the DUT, starting and ending one step after a rising edge.
  // stall_mode: 0 ready always, 1 random ready, 2 three-cycle stall at round 4.
  task automatic do_seq(input logic [63:0] k, input logic dec, input int stall_mode,
                        input int inject_idx, input logic [63:0] inject_key, input int reset_idx);
    int idx       = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    bit injected  = 0;
    bit rdy;
    check_val("key_ready_idle", 64'(key_ready), 64'd1);
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom};
    decrypt   = ~dec;
    while (idx < 16 && cyc < 100) begin
      if (idx == reset_idx) begin
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_subkey_valid", 64'(subkey_valid), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_round_idx", 64'(round_idx), 64'd0);
        check_val("rst_key_ready", 64'(key_ready), 64'd1);
        check_val("rst_subkey", 64'(subkey), 64'd0);
        subkey_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      check_val("subkey_valid", 64'(subkey_valid), 64'd1);
      check_val("key_ready_busy", 64'(key_ready), 64'd0);
      check_val("done_low", 64'(done), 64'd0);
      check_val("round_idx", 64'(round_idx), 64'(idx));
      check_val("subkey", 64'(subkey), 64'(exp_sk[idx]));
      key_valid = 1'b0;
      if (idx == inject_idx && !injected) begin
        key_valid = 1'b1;
        key_in    = inject_key;
        decrypt   = ~dec;
        injected  = 1;
      end
      case (stall_mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(idx == 4 && stall_cnt < 3);
        default: rdy = 1'b1;
      endcase
      if (!rdy) stall_cnt++;
      subkey_ready = rdy;
      if (rdy) got_sk[idx] = subkey;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    subkey_ready = 1'b0;
    key_valid    = 1'b0;
    check_val("seq_len", 64'(idx), 64'd16);
    if (stall_mode == 0) check_val("seq_cycles", 64'(cyc), 64'd16);
    check_val("done_pulse", 64'(done), 64'd1);
    check_val("key_ready_done", 64'(key_ready), 64'd1);
    check_val("valid_after", 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] k2;
    logic [63:0] kr;
    logic        dr;
    rst_n        = 1'b0;
    key_in       = '0;
    decrypt      = 1'b0;
    key_valid    = 1'b0;
    subkey_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_key_ready", 64'(key_ready), 64'd1);
    check_val("reset_valid", 64'(subkey_valid), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    check_val("reset_round_idx", 64'(round_idx), 64'd0);
    check_val("reset_subkey", 64'(subkey), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    build_exp(KEY_STD, 1'b0);
    do_seq(KEY_STD, 1'b0, 0, -1, '0, -1);
    check_val("enc_k1", 64'(got_sk[0]), 64'h1B02EFFC7072);
    check_val("enc_k2", 64'(got_sk[1]), 64'h79AED9DBC9E5);
    check_val("enc_k16", 64'(got_sk[15]), 64'hCB3D8B0E17F5);
    @(posedge clk); #1;
    check_val("done_one_cycle", 64'(done), 64'd0);

    build_exp(KEY_STD, 1'b1);
    do_seq(KEY_STD, 1'b1, 0, -1, '0, -1);
    check_val("dec_r0", 64'(got_sk[0]), 64'hCB3D8B0E17F5);
    check_val("dec_r14", 64'(got_sk[14]), 64'h79AED9DBC9E5);
    check_val("dec_r15", 64'(got_sk[15]), 64'h1B02EFFC7072);

    build_exp(KEY_STD, 1'b0);
    do_seq(KEY_STD, 1'b0, 2, -1, '0, -1);
    check_val("bp_k16", 64'(got_sk[15]), 64'hCB3D8B0E17F5);

    k2 = {$urandom, $urandom};
    build_exp(KEY_STD, 1'b0);
    do_seq(KEY_STD, 1'b0, 0, 7, k2, -1);
    build_exp(k2, 1'b1);
    do_seq(k2, 1'b1, 0, -1, '0, -1);

    build_exp(KEY_STD, 1'b0);
    do_seq(KEY_STD, 1'b0, 0, -1, '0, 8);
    do_seq(KEY_STD, 1'b0, 0, -1, '0, -1);
    check_val("post_reset_k1", 64'(got_sk[0]), 64'h1B02EFFC7072);

    build_exp(KEY_STD, 1'b0);
    do_seq(KEY_STD ^ 64'h0101010101010101, 1'b0, 1, -1, '0, -1);
    check_val("parity_k16", 64'(got_sk[15]), 64'hCB3D8B0E17F5);

    build_exp(64'h0, 1'b0);
    do_seq(64'h0, 1'b0, 0, -1, '0, -1);
    check_val("zero_k8", 64'(got_sk[7]), 64'h0);

    for (int n = 0; n < 8; n++) begin
      kr = {$urandom, $urandom};
      dr = 1'($urandom_range(0, 1));
      build_exp(kr, dr);
      do_seq(kr, dr, 1, -1, '0, -1);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
